// File: rtl/reg_file_scrub_if.sv
// Register-file port bundle: two read ports, one write port, and the scrub busy flag.
interface reg_file_scrub_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  reg_write;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic                  busy;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2, busy
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2, busy
  );
endinterface

// File: rtl/reg_file_scrub.sv
// ALU operand register file (r0 hardwired to zero) whose array is cleared by a post-reset scrub.
// Optional same-cycle write-to-read bypass: define REG_FILE_WRITE_BYPASS_EN.
module reg_file_scrub #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  reg_file_scrub_if.slave  rf
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]            state_reg;
  logic [ADDR_WIDTH-1:0] count_reg;
  logic                  busy;
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  assign busy    = (state_reg == CLEAR);
  assign rf.busy = busy;

  // Only the control state is reset; the array is cleared by the scrub instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= CLEAR;
      count_reg <= '0;
    end else if (state_reg == CLEAR) begin
      if (&count_reg) begin
        state_reg <= READY;
        count_reg <= '0;
      end else begin
        count_reg <= count_reg + ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      mem[count_reg] <= '0;
    end else if (rf.reg_write && rf.write_reg != '0) begin
      mem[rf.write_reg] <= rf.write_data;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : rd_port
      logic [ADDR_WIDTH-1:0] idx;
      logic [DATA_WIDTH-1:0] val;

      assign idx = (gi == 0) ? rf.read_reg1 : rf.read_reg2;

      // Reads are masked while scrubbing so stale or X contents never reach the ALU.
      always_comb begin
        val = '0;
        if (!busy && idx != '0) begin
          val = mem[idx];
`ifdef REG_FILE_WRITE_BYPASS_EN
          if (rf.reg_write && rf.write_reg == idx) begin
            val = rf.write_data;
          end
`endif
        end
      end
    end
  endgenerate

  assign rf.read_data1 = rd_port[0].val;
  assign rf.read_data2 = rd_port[1].val;
endmodule

// File: tb/tb_reg_file_scrub.sv
// Scoreboard bench for reg_file_scrub: expectations are queued at drive time and popped when sampled.
module tb_reg_file_scrub;
  logic clk;
  logic reset;

  reg_file_scrub_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) rf ();

  reg_file_scrub #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (rf.slave)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    rf.write_reg  = addr;
    rf.write_data = data;
    rf.reg_write  = 1'b1;
    @(posedge clk);
    #1;
    rf.reg_write  = 1'b0;
  endtask

  // Counts rising edges until busy drops; gives up after 40 edges.
  task automatic wait_scrub(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (!rf.busy) break;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    rf.reg_write = 1'b0; rf.write_reg = '0; rf.write_data = '0;
    rf.read_reg1 = 5'd5; rf.read_reg2 = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back('{d1: 32'h0, d2: 32'h0, busy: 1'b1});
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2 || rf.busy !== e.busy) begin
      errors++;
      $display("FAIL reset_state: got d1=%h d2=%h busy=%b want d1=%h d2=%h busy=%b",
               rf.read_data1, rf.read_data2, rf.busy, e.d1, e.d2, e.busy);
    end else $display("tx reset_state d1=%h d2=%h busy=%b", rf.read_data1, rf.read_data2, rf.busy);
  endtask

  task automatic test_scrub_timing();
    exp_t e;
    int n;
    @(negedge clk);
    rf.reg_write = 1'b1; rf.write_reg = 5'd5; rf.write_data = 32'hDEADBEEF;
    reset = 1'b0;
    wait_scrub(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL scrub_edges: got %0d edges want 32", n);
    end else $display("tx scrub_edges %0d", n);
    rf.reg_write = 1'b0;
    rf.read_reg1 = 5'd5; rf.read_reg2 = 5'd5;
    exp_q.push_back('{d1: 32'h0, d2: 32'h0, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2 || rf.busy !== e.busy) begin
      errors++;
      $display("FAIL scrub_ignores_write: got d1=%h d2=%h busy=%b want d1=%h d2=%h busy=%b",
               rf.read_data1, rf.read_data2, rf.busy, e.d1, e.d2, e.busy);
    end else $display("tx scrub_ignores_write d1=%h d2=%h", rf.read_data1, rf.read_data2);
  endtask

  task automatic test_basic_rw();
    exp_t e;
    do_write(5'd2, 32'h00000020);
    do_write(5'd3, 32'h00000014);
    @(negedge clk);
    rf.read_reg1 = 5'd3; rf.read_reg2 = 5'd2;
    exp_q.push_back('{d1: 32'h14, d2: 32'h20, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2 || rf.busy !== e.busy) begin
      errors++;
      $display("FAIL basic_rw: got d1=%h d2=%h busy=%b want d1=%h d2=%h busy=%b",
               rf.read_data1, rf.read_data2, rf.busy, e.d1, e.d2, e.busy);
    end else $display("tx basic_rw d1=%h d2=%h", rf.read_data1, rf.read_data2);
    rf.read_reg1 = 5'd2; rf.read_reg2 = 5'd2;
    exp_q.push_back('{d1: 32'h20, d2: 32'h20, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2) begin
      errors++;
      $display("FAIL same_reg_both_ports: got d1=%h d2=%h want d1=%h d2=%h",
               rf.read_data1, rf.read_data2, e.d1, e.d2);
    end else $display("tx same_reg_both_ports d1=%h d2=%h", rf.read_data1, rf.read_data2);
  endtask

  task automatic test_reg0();
    exp_t e;
    do_write(5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    rf.read_reg1 = 5'd0; rf.read_reg2 = 5'd0;
    exp_q.push_back('{d1: 32'h0, d2: 32'h0, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2) begin
      errors++;
      $display("FAIL reg0_write: got d1=%h d2=%h want d1=%h d2=%h",
               rf.read_data1, rf.read_data2, e.d1, e.d2);
    end else $display("tx reg0_write d1=%h d2=%h", rf.read_data1, rf.read_data2);
  endtask

  task automatic test_collision();
    exp_t e;
    logic [31:0] same_cycle;
`ifdef REG_FILE_WRITE_BYPASS_EN
    same_cycle = 32'h2;
`else
    same_cycle = 32'h1;
`endif
    do_write(5'd7, 32'h1);
    @(negedge clk);
    rf.write_reg = 5'd7; rf.write_data = 32'h2; rf.reg_write = 1'b1;
    rf.read_reg1 = 5'd7; rf.read_reg2 = 5'd7;
    exp_q.push_back('{d1: same_cycle, d2: same_cycle, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2) begin
      errors++;
      $display("FAIL collision_same_cycle: got d1=%h d2=%h want d1=%h d2=%h",
               rf.read_data1, rf.read_data2, e.d1, e.d2);
    end else $display("tx collision_same_cycle d1=%h d2=%h", rf.read_data1, rf.read_data2);
    @(posedge clk);
    #1;
    rf.reg_write = 1'b0;
    exp_q.push_back('{d1: 32'h2, d2: 32'h2, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2) begin
      errors++;
      $display("FAIL collision_next_cycle: got d1=%h d2=%h want d1=%h d2=%h",
               rf.read_data1, rf.read_data2, e.d1, e.d2);
    end else $display("tx collision_next_cycle d1=%h d2=%h", rf.read_data1, rf.read_data2);
    // A write to r0 must not bypass to a read of r0.
    @(negedge clk);
    rf.write_reg = 5'd0; rf.write_data = 32'h12345678; rf.reg_write = 1'b1;
    rf.read_reg1 = 5'd0; rf.read_reg2 = 5'd7;
    exp_q.push_back('{d1: 32'h0, d2: 32'h2, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2) begin
      errors++;
      $display("FAIL reg0_no_bypass: got d1=%h d2=%h want d1=%h d2=%h",
               rf.read_data1, rf.read_data2, e.d1, e.d2);
    end else $display("tx reg0_no_bypass d1=%h d2=%h", rf.read_data1, rf.read_data2);
    @(posedge clk);
    #1;
    rf.reg_write = 1'b0;
  endtask

  task automatic test_ready_reset();
    exp_t e;
    int n;
    do_write(5'd31, 32'hA5A5A5A5);
    rf.read_reg1 = 5'd31; rf.read_reg2 = 5'd3;
    exp_q.push_back('{d1: 32'hA5A5A5A5, d2: 32'h14, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2 || rf.busy !== e.busy) begin
      errors++;
      $display("FAIL ready_load: got d1=%h d2=%h busy=%b want d1=%h d2=%h busy=%b",
               rf.read_data1, rf.read_data2, rf.busy, e.d1, e.d2, e.busy);
    end else $display("tx ready_load d1=%h d2=%h", rf.read_data1, rf.read_data2);
    #1;
    reset = 1'b1;
    exp_q.push_back('{d1: 32'h0, d2: 32'h0, busy: 1'b1});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2 || rf.busy !== e.busy) begin
      errors++;
      $display("FAIL ready_reset_async: got d1=%h d2=%h busy=%b want d1=%h d2=%h busy=%b",
               rf.read_data1, rf.read_data2, rf.busy, e.d1, e.d2, e.busy);
    end else $display("tx ready_reset_async busy=%b", rf.busy);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    wait_scrub(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL ready_reset_scrub_edges: got %0d edges want 32", n);
    end else $display("tx ready_reset_scrub_edges %0d", n);
    exp_q.push_back('{d1: 32'h0, d2: 32'h0, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2 || rf.busy !== e.busy) begin
      errors++;
      $display("FAIL ready_reset_cleared: got d1=%h d2=%h busy=%b want d1=%h d2=%h busy=%b",
               rf.read_data1, rf.read_data2, rf.busy, e.d1, e.d2, e.busy);
    end else $display("tx ready_reset_cleared d1=%h d2=%h", rf.read_data1, rf.read_data2);
  endtask

  task automatic test_mid_scrub_reset();
    exp_t e;
    int n;
    do_write(5'd20, 32'hCAFEF00D);
    rf.read_reg1 = 5'd20; rf.read_reg2 = 5'd20;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.push_back('{d1: 32'h0, d2: 32'h0, busy: 1'b1});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2 || rf.busy !== e.busy) begin
      errors++;
      $display("FAIL mid_scrub_reset: got d1=%h d2=%h busy=%b want d1=%h d2=%h busy=%b",
               rf.read_data1, rf.read_data2, rf.busy, e.d1, e.d2, e.busy);
    end else $display("tx mid_scrub_reset busy=%b", rf.busy);
    @(negedge clk);
    reset = 1'b0;
    wait_scrub(n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL mid_scrub_restart_edges: got %0d edges want 32", n);
    end else $display("tx mid_scrub_restart_edges %0d", n);
    exp_q.push_back('{d1: 32'h0, d2: 32'h0, busy: 1'b0});
    #1;
    e = exp_q.pop_front(); checks++;
    if (rf.read_data1 !== e.d1 || rf.read_data2 !== e.d2 || rf.busy !== e.busy) begin
      errors++;
      $display("FAIL mid_scrub_cleared: got d1=%h d2=%h busy=%b want d1=%h d2=%h busy=%b",
               rf.read_data1, rf.read_data2, rf.busy, e.d1, e.d2, e.busy);
    end else $display("tx mid_scrub_cleared d1=%h d2=%h", rf.read_data1, rf.read_data2);
  endtask

  initial begin
    test_reset();
    test_scrub_timing();
    test_basic_rw();
    test_reg0();
    test_collision();
    test_ready_reset();
    test_mid_scrub_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_scrub.md
Name: reg_file_scrub

Overview:
- Operand register file directly upstream of the 32-bit ALU; read_data1/read_data2 drive the ALU a/b inputs.
- Provides two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- After reset, a scrub state machine clears the storage array one entry per cycle. This avoids an asynchronous reset on the whole array. busy flags the scrub to the core.

Parameters:
- DATA_WIDTH, 32: register width; matches the ALU operand width.
- ADDR_WIDTH, 5: register index width. NUM_REGS = 2**ADDR_WIDTH (internal, derived).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- read_reg1  input  ADDR_WIDTH  read port 1 index
- read_reg2  input  ADDR_WIDTH  read port 2 index
- write_reg  input  ADDR_WIDTH  write index
- write_data  input  DATA_WIDTH  write value
- reg_write  input  1  write enable
- read_data1  output  DATA_WIDTH  port 1 data (ALU operand a)
- read_data2  output  DATA_WIDTH  port 2 data (ALU operand b)
- busy  output  1  high while scrub in progress

Behaviour:
- Reset/clock: one clock, clk. reset is asynchronous, active-high.
- While reset is high:
  - state = CLEAR, scrub counter = 0, busy = 1.
  - read_data1 = read_data2 = 0.
  - Storage array is not reset directly.
- States:
  - CLEAR:
    - Each rising edge writes 0 to entry[counter], then increments counter.
    - On the edge that clears entry NUM_REGS-1, go to READY and drop busy. Counter returns to 0.
    - Scrub latency: exactly NUM_REGS (32) rising edges after reset deasserts. busy is low after edge 32.
  - READY: normal operation; no exit except reset.
- While busy:
  - Both read outputs are forced to 0.
  - reg_write is ignored; no architectural write occurs.
- Reads (READY):
  - Combinational; read_data = entry[read_reg].
  - Index 0 always returns 0, regardless of array contents.
- Writes (READY):
  - On a rising edge with reg_write = 1 and write_reg != 0, entry[write_reg] <= write_data.
  - Writes to index 0 are discarded.
- Same-cycle read/write to the same nonzero index (macro off): the read returns the old value; the new value is visible from the next cycle.
- Both read ports may address the same register simultaneously; both return the same value.
- Reset asserted mid-scrub: counter returns to 0 immediately and the scrub restarts from entry 0 after release.
- Reset asserted in READY: same as power-on. Contents are cleared only by the subsequent scrub.
- No X may propagate to read_data after busy falls, even if the array powered up as X.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN.
- Defined: a read port returns write_data combinationally when all of the following hold in the same cycle:
  - reg_write = 1
  - busy = 0
  - write_reg != 0
  - write_reg equals that port's read index
- The bypass serves a write-then-read in the same cycle for a single-cycle core with a split-phase register file.
- Undefined: no bypass; a same-cycle read returns the old stored value.
- Neither setting changes behaviour for index 0 or during busy.

Test Plan:
- Scrub timing: assert reset for 3 cycles, release, hold reg_write = 1 with write_reg = 5, write_data = 32'hDEADBEEF throughout -> busy high for exactly 32 edges, then low; reading index 5 after busy falls returns 0 (writes during scrub ignored).
- Basic write/read: after scrub, write 32'h00000020 to reg 2 and 32'h00000014 to reg 3; set read_reg1 = 3, read_reg2 = 2 -> read_data1 = 32'h14, read_data2 = 32'h20 (ALU add inputs a = 20, b = 32).
- Register 0: write 32'hFFFFFFFF to reg 0; read reg 0 on both ports -> both read 0.
- Same-cycle collision: reg 7 holds 32'h1; in one cycle write 32'h2 to reg 7 while reading reg 7 -> 32'h1 without REG_FILE_WRITE_BYPASS_EN, 32'h2 with it; next cycle both builds read 32'h2.
- Mid-scrub reset: release reset, wait 10 edges, assert reset asynchronously between edges -> busy stays high and outputs are 0 immediately; after release, busy lasts a full 32 edges.
- Reset in READY: load reg 31 = 32'hA5A5A5A5, assert reset, complete scrub -> reg 31 reads 0.
